// File: rtl/regfile_writeback_pkg.sv
// Writeback-stage local definitions: buffer depth default and commit source select.
package regfile_writeback_pkg;

    localparam int unsigned LD_DEPTH_DEFAULT = 2;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_ALU  = 2'd1,
        SEL_LD   = 2'd2
    } sel_t;

endpackage

// File: rtl/rv_pkg.sv
// Shared RISC-V definitions: default datapath widths and load funct3 encodings.
package rv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/regfile_writeback_if.sv
// ALU-result and load-result handshake bundle feeding the writeback stage.
interface regfile_writeback_if #(
    parameter int unsigned DATA_WIDTH    = rv_pkg::XLEN,
    parameter int unsigned ADDRESS_WIDTH = rv_pkg::REG_AW
);

    logic                     alu_valid;
    logic                     alu_ready;
    logic [ADDRESS_WIDTH-1:0] alu_rd;
    logic [DATA_WIDTH-1:0]    alu_data;

    logic                     ld_valid;
    logic                     ld_ready;
    logic [ADDRESS_WIDTH-1:0] ld_rd;
    logic [DATA_WIDTH-1:0]    ld_raw;
    logic [2:0]               ld_funct3;
    logic [1:0]               ld_addr_lo;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_raw, ld_funct3, ld_addr_lo,
        input  alu_ready, ld_ready
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_raw, ld_funct3, ld_addr_lo,
        output alu_ready, ld_ready
    );

endinterface

// File: rtl/regfile_writeback_load_formatter.sv
// Combinational load formatter: lane select and sign/zero extension by funct3.
module load_formatter
    import rv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = XLEN
) (
    input  logic [DATA_WIDTH-1:0] raw,
    input  logic [2:0]            funct3,
    input  logic [1:0]            addr_lo,
    output logic [DATA_WIDTH-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/half and extend it; unknown codes behave as LW.
    always_comb begin
        byte_sel = raw[{addr_lo, 3'b000} +: 8];
        half_sel = raw[{addr_lo[1], 4'b0000} +: 16];
        data     = raw;
        case (funct3)
            F3_LB:   data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            F3_LBU:  data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            F3_LHU:  data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            F3_LW:   data = raw;
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback arbiter: ALU results and buffered, formatted loads share one
// register-file write port. Loads stay in order; ALU results may overtake them.
module regfile_writeback
    import rv_pkg::*;
    import regfile_writeback_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = XLEN,
    parameter int unsigned ADDRESS_WIDTH = REG_AW,
    parameter int unsigned LD_DEPTH      = LD_DEPTH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    regfile_writeback_if.slave          bus,
    output logic                        rf_we,
    output logic [ADDRESS_WIDTH-1:0]    rf_waddr,
    output logic [DATA_WIDTH-1:0]       rf_wdata,
    output logic [2**ADDRESS_WIDTH-1:0] busy_mask
);

    localparam int unsigned      CW      = $clog2(LD_DEPTH + 1);
    localparam int unsigned      PW      = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
    localparam logic [CW-1:0]    DEPTH_C = CW'(LD_DEPTH);
    localparam logic [PW-1:0]    LAST_C  = PW'(LD_DEPTH - 1);

    logic [CW-1:0]            count;
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [LD_DEPTH-1:0]      slot_valid;
    logic [ADDRESS_WIDTH-1:0] slot_rd   [LD_DEPTH];
    logic [DATA_WIDTH-1:0]    slot_data [LD_DEPTH];

    logic [DATA_WIDTH-1:0]    ld_fmt;
    logic                     ready;
    logic                     alu_fire;
    logic                     ld_fire;
    logic                     pop;
    sel_t                     sel;
    logic [ADDRESS_WIDTH-1:0] cand_rd;
    logic [DATA_WIDTH-1:0]    cand_data;

    load_formatter #(.DATA_WIDTH(DATA_WIDTH)) u_fmt (
        .raw     (bus.ld_raw),
        .funct3  (bus.ld_funct3),
        .addr_lo (bus.ld_addr_lo),
        .data    (ld_fmt)
    );

    assign ready         = (count < DEPTH_C);
    assign bus.alu_ready = ready;
    assign bus.ld_ready  = ready;
    assign alu_fire      = bus.alu_valid & ready;
    assign ld_fire       = bus.ld_valid & ready;
    assign pop           = (sel == SEL_LD);

    // Commit candidate: a full buffer drains first, otherwise ALU beats loads.
    always_comb begin
        sel       = SEL_NONE;
        cand_rd   = '0;
        cand_data = '0;
        if (count == DEPTH_C) begin
            sel = SEL_LD;
        end else if (alu_fire) begin
            sel = SEL_ALU;
        end else if (count != '0) begin
            sel = SEL_LD;
        end
        case (sel)
            SEL_ALU: begin
                cand_rd   = bus.alu_rd;
                cand_data = bus.alu_data;
            end
            SEL_LD: begin
                cand_rd   = slot_rd[rd_ptr];
                cand_data = slot_data[rd_ptr];
            end
            default: ;
        endcase
    end

    // In-order load buffer; push and pop never target the same slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            slot_valid <= '0;
            for (int unsigned i = 0; i < LD_DEPTH; i++) begin
                slot_rd[i]   <= '0;
                slot_data[i] <= '0;
            end
        end else begin
            if (ld_fire) begin
                slot_rd[wr_ptr]    <= bus.ld_rd;
                slot_data[wr_ptr]  <= ld_fmt;
                slot_valid[wr_ptr] <= 1'b1;
                wr_ptr             <= (wr_ptr == LAST_C) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                slot_valid[rd_ptr] <= 1'b0;
                rd_ptr             <= (rd_ptr == LAST_C) ? '0 : rd_ptr + PW'(1);
            end
            case ({ld_fire, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Register the selected commit; writes to x0 are consumed silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we    <= (sel != SEL_NONE) && (cand_rd != '0);
            rf_waddr <= cand_rd;
            rf_wdata <= cand_data;
        end
    end

    // Flag destinations that still have a buffered load pending.
    always_comb begin
        busy_mask = '0;
        for (int unsigned i = 0; i < LD_DEPTH; i++) begin
            if (slot_valid[i] && (slot_rd[i] != '0)) begin
                busy_mask[slot_rd[i]] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed vector table, corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_regfile_writeback;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy_mask;

    int checks = 0;
    int errors = 0;

    regfile_writeback_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) bus ();

    regfile_writeback #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (5),
        .LD_DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .busy_mask (busy_mask)
    );

    always #5 clk = ~clk;

    // Reference model: pending loads as a plain queue of {rd, formatted data}.
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;
    ent_t mq[$];

    typedef struct {
        bit          is_ld;
        logic [4:0]  rd;
        logic [31:0] dat;
        logic [2:0]  f3;
        logic [1:0]  lo;
        bit          ewe;
        logic [4:0]  ewaddr;
        logic [31:0] ewdata;
    } vec_t;
    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fmt(input logic [31:0] raw, input logic [2:0] f3, input logic [1:0] lo);
        logic [31:0] b;
        logic [31:0] h;
        b = (raw >> (8 * lo)) & 32'hFF;
        h = (raw >> (16 * lo[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return raw;
        endcase
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] m = '0;
        foreach (mq[i]) if (mq[i].rd != 0) m[mq[i].rd] = 1'b1;
        return m;
    endfunction

    // One clock of traffic: drive, check readiness, advance model, check commit.
    task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] lraw,
                         input logic [2:0] lf3, input logic [1:0] lo);
        bit          rdy;
        bit          have;
        ent_t        c;
        bus.alu_valid  = av;
        bus.alu_rd     = ard;
        bus.alu_data   = adat;
        bus.ld_valid   = lv;
        bus.ld_rd      = lrd;
        bus.ld_raw     = lraw;
        bus.ld_funct3  = lf3;
        bus.ld_addr_lo = lo;
        #1;
        rdy  = (mq.size() < DEPTH);
        have = 1'b0;
        c    = '0;
        check("alu_ready", {63'd0, bus.alu_ready}, {63'd0, rdy});
        check("ld_ready", {63'd0, bus.ld_ready}, {63'd0, rdy});
        if (mq.size() == DEPTH) begin
            c = mq.pop_front(); have = 1'b1;
        end else if (av && rdy) begin
            c = '{rd: ard, data: adat}; have = 1'b1;
        end else if (mq.size() > 0) begin
            c = mq.pop_front(); have = 1'b1;
        end
        if (lv && rdy) mq.push_back('{rd: lrd, data: fmt(lraw, lf3, lo)});
        @(posedge clk);
        #1;
        check("rf_we", {63'd0, rf_we}, {63'd0, (have && c.rd != 0)});
        if (have && c.rd != 0) begin
            check("rf_waddr", {59'd0, rf_waddr}, {59'd0, c.rd});
            check("rf_wdata", {32'd0, rf_wdata}, {32'd0, c.data});
        end
        check("busy_mask", {32'd0, busy_mask}, {32'd0, model_busy()});
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{0, 5'd5,  32'h0000_1234, 3'b000, 2'd0, 1, 5'd5,  32'h0000_1234};
        vecs[1]  = '{1, 5'd9,  32'h80FF_7F01, 3'b000, 2'd3, 1, 5'd9,  32'hFFFF_FF80};
        vecs[2]  = '{1, 5'd10, 32'h80FF_7F01, 3'b101, 2'd2, 1, 5'd10, 32'h0000_80FF};
        vecs[3]  = '{1, 5'd11, 32'h80FF_7F01, 3'b010, 2'd0, 1, 5'd11, 32'h80FF_7F01};
        vecs[4]  = '{1, 5'd12, 32'h80FF_7F01, 3'b000, 2'd0, 1, 5'd12, 32'h0000_0001};
        vecs[5]  = '{1, 5'd13, 32'h80FF_7F01, 3'b001, 2'd0, 1, 5'd13, 32'h0000_7F01};
        vecs[6]  = '{1, 5'd14, 32'h80FF_7F01, 3'b001, 2'd2, 1, 5'd14, 32'hFFFF_80FF};
        vecs[7]  = '{1, 5'd15, 32'h80FF_7F01, 3'b100, 2'd3, 1, 5'd15, 32'h0000_0080};
        vecs[8]  = '{1, 5'd16, 32'h80FF_7F01, 3'b000, 2'd2, 1, 5'd16, 32'hFFFF_FFFF};
        vecs[9]  = '{1, 5'd17, 32'h80FF_7F01, 3'b011, 2'd1, 1, 5'd17, 32'h80FF_7F01};
        vecs[10] = '{1, 5'd18, 32'h80FF_7F01, 3'b100, 2'd1, 1, 5'd18, 32'h0000_007F};
        vecs[11] = '{0, 5'd0,  32'hDEAD_BEEF, 3'b000, 2'd0, 0, 5'd0,  32'h0};
        vecs[12] = '{1, 5'd0,  32'h80FF_7F01, 3'b010, 2'd0, 0, 5'd0,  32'h0};
        vecs[13] = '{0, 5'd31, 32'hFFFF_FFFF, 3'b000, 2'd0, 1, 5'd31, 32'hFFFF_FFFF};

        reset          = 1'b1;
        bus.alu_valid  = 1'b0;
        bus.alu_rd     = '0;
        bus.alu_data   = '0;
        bus.ld_valid   = 1'b0;
        bus.ld_rd      = '0;
        bus.ld_raw     = '0;
        bus.ld_funct3  = '0;
        bus.ld_addr_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rf_we", {63'd0, rf_we}, 64'd0);
        check("reset_rf_waddr", {59'd0, rf_waddr}, 64'd0);
        check("reset_rf_wdata", {32'd0, rf_wdata}, 64'd0);
        check("reset_busy", {32'd0, busy_mask}, 64'd0);
        reset = 1'b0;

        // Directed table: each vector starts from an empty buffer.
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].is_ld) begin
                cycle(1'b0, 5'd0, 32'd0, 1'b1, vecs[i].rd, vecs[i].dat, vecs[i].f3, vecs[i].lo);
                check("vec_ld_latency_we", {63'd0, rf_we}, 64'd0);
                idle();
            end else begin
                cycle(1'b1, vecs[i].rd, vecs[i].dat, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
            end
            check($sformatf("vec%0d_we", i), {63'd0, rf_we}, {63'd0, vecs[i].ewe});
            if (vecs[i].ewe) begin
                check($sformatf("vec%0d_waddr", i), {59'd0, rf_waddr}, {59'd0, vecs[i].ewaddr});
                check($sformatf("vec%0d_wdata", i), {32'd0, rf_wdata}, {32'd0, vecs[i].ewdata});
            end
        end

        // Load x7 and ALU x8 together: ALU first, load one cycle later.
        cycle(1'b1, 5'd8, 32'h0000_0888, 1'b1, 5'd7, 32'h1357_9BDF, 3'b010, 2'd0);
        check("ovt_alu_addr", {59'd0, rf_waddr}, 64'd8);
        check("ovt_busy7", {63'd0, busy_mask[7]}, 64'd1);
        idle();
        check("ovt_ld_addr", {59'd0, rf_waddr}, 64'd7);
        check("ovt_ld_data", {32'd0, rf_wdata}, 64'h1357_9BDF);
        check("ovt_busy_clear", {32'd0, busy_mask}, 64'd0);

        // Fill the buffer, then hold an ALU result while the head drains.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h0000_0033, 3'b010, 2'd0);
        cycle(1'b1, 5'd20, 32'h0000_0020, 1'b1, 5'd4, 32'h0000_0044, 3'b010, 2'd0);
        check("full_busy", {32'd0, busy_mask}, 64'h18);
        check("full_alu_ready", {63'd0, bus.alu_ready}, 64'd0);
        cycle(1'b1, 5'd21, 32'h0000_0021, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
        check("full_head_addr", {59'd0, rf_waddr}, 64'd3);
        cycle(1'b1, 5'd21, 32'h0000_0021, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
        check("full_alu_addr", {59'd0, rf_waddr}, 64'd21);
        idle();
        check("full_tail_addr", {59'd0, rf_waddr}, 64'd4);

        // Reset with two loads buffered: everything is discarded.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h0000_0033, 3'b010, 2'd0);
        cycle(1'b1, 5'd20, 32'h0000_0020, 1'b1, 5'd4, 32'h0000_0044, 3'b010, 2'd0);
        check("prerst_busy", {32'd0, busy_mask}, 64'h18);
        bus.alu_valid = 1'b0;
        bus.ld_valid  = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("rst_busy", {32'd0, busy_mask}, 64'd0);
        check("rst_rf_we", {63'd0, rf_we}, 64'd0);
        check("rst_ready", {63'd0, bus.ld_ready}, 64'd1);
        mq.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) idle();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                  3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        end
        repeat (3) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 5, register index width.
REQ-003 SHALL have parameter LD_DEPTH, default 2, load-result buffer entries.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports alu_valid/alu_ready  input/output  1/1  ALU result handshake.
REQ-007 SHALL have ports alu_rd, alu_data  input  ADDRESS_WIDTH, DATA_WIDTH  ALU destination and result.
REQ-008 SHALL have ports ld_valid/ld_ready  input/output  1/1  load-result handshake.
REQ-009 SHALL have ports ld_rd, ld_raw, ld_funct3, ld_addr_lo  input  ADDRESS_WIDTH, DATA_WIDTH, 3, 2  load destination, raw memory word, load type, byte offset.
REQ-010 SHALL have ports rf_we, rf_waddr, rf_wdata  output  1, ADDRESS_WIDTH, DATA_WIDTH  register-file write port.
REQ-011 SHALL have port busy_mask  output  2**ADDRESS_WIDTH  one bit per register with a buffered, uncommitted load.

Function
REQ-012 SHALL accept a transfer on a source when valid and ready are both high at a rising edge.
REQ-013 SHALL drive ld_ready = (count < LD_DEPTH) and alu_ready = (count < LD_DEPTH), from registered count only.
REQ-014 SHALL format an accepted load before buffering: funct3 000 LB sign-extend byte ld_addr_lo; 001 LH sign-extend half ld_addr_lo[1]; 010 LW word; 100 LBU zero-extend; 101 LHU zero-extend; other codes treated as LW.
REQ-015 SHALL push each accepted load (rd, formatted data) into an in-order FIFO of LD_DEPTH entries.
REQ-016 SHALL select per cycle one commit candidate: FIFO head when count==LD_DEPTH; else accepted ALU result; else FIFO head when count>0; else none.
REQ-017 SHALL register the commit: rf_we/rf_waddr/rf_wdata valid the cycle after selection (ALU latency 1, load latency >=2).
REQ-018 SHALL pop the FIFO head in the cycle it is selected; simultaneous push and pop leave count unchanged.
REQ-019 SHALL, for rd==0, consume the transfer or entry but hold rf_we low.
REQ-020 SHALL hold rf_we low in cycles with no candidate; rf_waddr/rf_wdata then don't-care.
REQ-021 SHALL set busy_mask bit r when any FIFO entry has rd==r and r!=0, from registered FIFO state.
REQ-022 SHALL never lose or reorder loads; ALU results may overtake buffered loads.

Reset
REQ-023 SHALL on reset clear count, FIFO pointers, rf_we=0, rf_waddr=0, rf_wdata=0, busy_mask=0.
REQ-024 SHALL discard buffered loads on reset mid-operation; no write after reset deasserts until a new transfer.
REQ-025 SHALL present alu_ready=ld_ready=1 in the first cycle after reset.

Structure
REQ-026 SHALL take load funct3 encodings and DATA_WIDTH/ADDRESS_WIDTH defaults from the shared RISC-V package (rv_pkg).
REQ-027 SHALL implement the load formatter as combinational sub-module load_formatter.
REQ-028 SHALL keep the FIFO inline; one clock domain, no latches.

Verification
REQ-029 SHALL cover: ALU x5=0x1234 only -> next cycle rf_we=1, waddr=5, wdata=0x00001234.
REQ-030 SHALL cover: LB raw=0x80FF7F01, addr_lo=3 -> wdata=0xFFFFFF80; LHU addr_lo=2 -> 0x000080FF; LW -> 0x80FF7F01.
REQ-031 SHALL cover: load x7 and ALU x8 same cycle -> x8 committed cycle+1, x7 cycle+2; busy_mask[7]=1 until then.
REQ-032 SHALL cover: 2 loads buffered with alu_valid held -> alu_ready=0, ld_ready=0, head drains, then ALU commits.
REQ-033 SHALL cover: ALU to x0 with data 0xDEADBEEF -> alu_ready=1, rf_we stays 0.
REQ-034 SHALL cover: reset asserted with count=2 -> count=0, busy_mask=0, no rf_we after release.
